// File: rtl/level_ctrl.sv
// level_ctrl: game difficulty level FSM with hit counting, miss hold-off and game-clock tick extraction
//   clk_lf    in   system clock
//   btnC_n    in   asynchronous active-low reset
//   clk_game  in   divided game clock, asynchronous, treated as data
//   start     in   one-cycle pulse, begins a game from IDLE
//   hit       in   one-cycle pulse, paddle hit
//   miss      in   one-cycle pulse, missed ball
//   level     out  difficulty level 0..3 (registered)
//   level_up  out  one-cycle pulse when level increases (registered)
//   freeze    out  high while in HOLD (registered)
//   game_tick out  one-cycle pulse per clk_game rising edge
//   state     out  FSM state: IDLE=00, PLAY=01, HOLD=10
module level_ctrl #(
    parameter int HITS_PER_LEVEL = 4,
    parameter int HOLD_TICKS     = 3,
    parameter int DROP_ON_MISS   = 1
) (
    input  logic       clk_lf,
    input  logic       btnC_n,
    input  logic       clk_game,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    output logic [1:0] level,
    output logic       level_up,
    output logic       freeze,
    output logic       game_tick,
    output logic [1:0] state
);
    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, HOLD = 2'b10} state_t;

    state_t     state_q, state_d;
    logic [1:0] level_q, level_d;
    logic       level_up_q, level_up_d;
    logic       freeze_q;
    logic [3:0] hit_cnt_q, hit_cnt_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [2:0] sync_q;

    // two synchronizer stages plus an edge-detect stage
    assign game_tick = sync_q[1] & ~sync_q[2];

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        level_up_d = 1'b0;
        hit_cnt_d  = hit_cnt_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                level_d   = 2'd0;
                hit_cnt_d = 4'd0;
                if (start) state_d = PLAY;
            end
            PLAY: begin
                // a simultaneous hit is discarded: the miss wins
                if (miss) begin
                    state_d    = HOLD;
                    hit_cnt_d  = 4'd0;
                    hold_cnt_d = 4'(HOLD_TICKS);
                    if (DROP_ON_MISS == 1 && level_q != 2'd0) level_d = level_q - 2'd1;
                end else if (hit) begin
                    if (hit_cnt_q == 4'(HITS_PER_LEVEL - 1)) begin
                        hit_cnt_d = 4'd0;
                        if (level_q != 2'd3) begin
                            level_d    = level_q + 2'd1;
                            level_up_d = 1'b1;
                        end
                    end else begin
                        hit_cnt_d = hit_cnt_q + 4'd1;
                    end
                end
            end
            HOLD: begin
                if (game_tick) begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                    if (hold_cnt_q == 4'd1) state_d = PLAY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_lf or negedge btnC_n) begin
        if (!btnC_n) begin
            state_q    <= IDLE;
            level_q    <= 2'd0;
            level_up_q <= 1'b0;
            freeze_q   <= 1'b0;
            hit_cnt_q  <= 4'd0;
            hold_cnt_q <= 4'd0;
            sync_q     <= 3'd0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            level_up_q <= level_up_d;
            // decoded from next state so freeze lines up with state
            freeze_q   <= (state_d == HOLD);
            hit_cnt_q  <= hit_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            sync_q     <= {sync_q[1:0], clk_game};
        end
    end

    assign level    = level_q;
    assign level_up = level_up_q;
    assign freeze   = freeze_q;
    assign state    = state_q;
endmodule

// File: tb/tb_level_ctrl.sv
// tb_level_ctrl: scoreboard bench for level_ctrl; expected output vectors are queued by stimulus, monitor pops on each output change
module tb_level_ctrl;
    logic       clk_lf = 1'b0;
    logic       btnC_n, clk_game, start, hit, miss;
    logic [1:0] level, state;
    logic       level_up, freeze, game_tick;

    int checks = 0;
    int failures = 0;

    logic [5:0] sb_v[$];
    string      sb_t[$];
    logic [5:0] mon_cur;
    logic [5:0] mon_prev = 6'd0;

    level_ctrl dut (
        .clk_lf(clk_lf), .btnC_n(btnC_n), .clk_game(clk_game), .start(start),
        .hit(hit), .miss(miss), .level(level), .level_up(level_up),
        .freeze(freeze), .game_tick(game_tick), .state(state)
    );

    always #5 clk_lf = ~clk_lf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] st, input logic [1:0] lv, input logic lu, input logic fz, input string tag);
        sb_v.push_back({st, lv, lu, fz});
        sb_t.push_back(tag);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_lf);
            #1;
        end
    endtask

    task automatic hits(input int n);
        hit = 1'b1;
        step(n);
        hit = 1'b0;
    endtask

    task automatic pulse_miss();
        miss = 1'b1;
        step(1);
        miss = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // one clk_game period of 16 clk_lf cycles; reports tick count and cycle of last tick
    task automatic game_period(output int n, output int pos);
        n = 0;
        pos = 0;
        clk_game = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk_lf);
            #1;
            if (game_tick) begin
                n++;
                pos = c;
            end
            if (c == 8) clk_game = 1'b0;
        end
    endtask

    task automatic reset_zero_checks(input string tag);
        check({tag, "_state"}, 32'(state), 0);
        check({tag, "_level"}, 32'(level), 0);
        check({tag, "_level_up"}, 32'(level_up), 0);
        check({tag, "_freeze"}, 32'(freeze), 0);
        check({tag, "_game_tick"}, 32'(game_tick), 0);
    endtask

    initial begin
        forever begin
            @(negedge clk_lf);
            mon_cur = {state, level, level_up, freeze};
            if (mon_cur !== mon_prev) begin
                if (sb_v.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_change: got %0h expected no change from %0h", mon_cur, mon_prev);
                end else begin
                    check(sb_t.pop_front(), 32'(mon_cur), 32'(sb_v.pop_front()));
                end
                mon_prev = mon_cur;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, pos;
        clk_game = 1'b0; start = 1'b0; hit = 1'b0; miss = 1'b0; btnC_n = 1'b1;
        #2 btnC_n = 1'b0;
        #1 reset_zero_checks("por");
        step(3);
        btnC_n = 1'b1;
        push(2'b01, 2'd0, 1'b0, 1'b0, "start_first_edge");
        pulse_start();
        push(2'b01, 2'd1, 1'b1, 1'b0, "lvl1_up");
        push(2'b01, 2'd1, 1'b0, 1'b0, "lvl1_up_end");
        hits(4);
        step(1);
        push(2'b01, 2'd2, 1'b1, 1'b0, "lvl2_up");
        push(2'b01, 2'd2, 1'b0, 1'b0, "lvl2_up_end");
        hits(4);
        step(1);
        push(2'b10, 2'd1, 1'b0, 1'b1, "miss_lvl2_hold");
        pulse_miss();
        hits(5);
        step(2);
        game_period(n, pos);
        game_period(n, pos);
        push(2'b01, 2'd1, 1'b0, 1'b0, "hold_release_1");
        game_period(n, pos);
        hits(3);
        push(2'b10, 2'd0, 1'b0, 1'b1, "hit_miss_same_cycle");
        hit = 1'b1;
        miss = 1'b1;
        step(1);
        hit = 1'b0;
        miss = 1'b0;
        pulse_start();
        game_period(n, pos);
        game_period(n, pos);
        push(2'b01, 2'd0, 1'b0, 1'b0, "hold_release_2");
        game_period(n, pos);
        push(2'b10, 2'd0, 1'b0, 1'b1, "miss_lvl0_nowrap");
        pulse_miss();
        game_period(n, pos);
        game_period(n, pos);
        push(2'b01, 2'd0, 1'b0, 1'b0, "hold_release_3");
        game_period(n, pos);
        push(2'b01, 2'd1, 1'b1, 1'b0, "climb_lvl1");
        push(2'b01, 2'd1, 1'b0, 1'b0, "climb_lvl1_end");
        push(2'b01, 2'd2, 1'b1, 1'b0, "climb_lvl2");
        push(2'b01, 2'd2, 1'b0, 1'b0, "climb_lvl2_end");
        push(2'b01, 2'd3, 1'b1, 1'b0, "climb_lvl3");
        push(2'b01, 2'd3, 1'b0, 1'b0, "climb_lvl3_end");
        hits(12);
        hits(8);
        pulse_start();
        step(2);
        for (int p = 0; p < 3; p++) begin
            game_period(n, pos);
            check($sformatf("tick_count_p%0d", p), 32'(n), 1);
            check($sformatf("tick_pos_p%0d", p), 32'(pos), 2);
        end
        push(2'b10, 2'd2, 1'b0, 1'b1, "miss_lvl3_hold");
        pulse_miss();
        game_period(n, pos);
        step(1);
        #2;
        push(2'b00, 2'd0, 1'b0, 1'b0, "reset_mid_hold");
        btnC_n = 1'b0;
        #1 reset_zero_checks("async_rst");
        @(posedge clk_lf);
        #1;
        btnC_n = 1'b1;
        pulse_miss();
        hits(2);
        step(3);
        push(2'b01, 2'd0, 1'b0, 1'b0, "restart_after_rst");
        pulse_start();
        step(3);
        check("sb_drain", 32'(sb_v.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/level_ctrl.md
LEVEL_CTRL -- requirements
Module: level_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk_lf is the only clock and btnC_n is the reset, asserted low, acting without a clock edge.
REQ-002 Parameter HITS_PER_LEVEL SHALL be provided: default 4; paddle hits needed to advance one level; legal range 1..15.
REQ-003 Parameter HOLD_TICKS SHALL be provided: default 3; game ticks the block stays frozen after a miss; legal range 1..15.
REQ-004 Parameter DROP_ON_MISS SHALL be provided: default 1; when 1, a miss lowers level by one.
REQ-005 Port clk_lf SHALL be: input, 1 bit, system clock.
REQ-006 Port btnC_n SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-007 Port clk_game SHALL be: input, 1 bit, divided game clock; asynchronous to this logic and treated as data.
REQ-008 Port start SHALL be: input, 1 bit, one-cycle pulse that begins a game.
REQ-009 Port hit SHALL be: input, 1 bit, one-cycle pulse for a paddle hit.
REQ-010 Port miss SHALL be: input, 1 bit, one-cycle pulse for a missed ball.
REQ-011 Port level SHALL be: output, 2 bits, difficulty level driven to the game-clock divider's level select.
REQ-012 Port level_up SHALL be: output, 1 bit, one-cycle pulse when level increases.
REQ-013 Port freeze SHALL be: output, 1 bit, high while in HOLD.
REQ-014 Port game_tick SHALL be: output, 1 bit, one-cycle pulse per clk_game rising edge.
REQ-015 Port state SHALL be: output, 2 bits, current FSM state encoded as IDLE=00, PLAY=01, HOLD=10.

Function
REQ-016 clk_game SHALL pass through a 2-flop synchronizer followed by a third flop; game_tick = sync2 & ~sync3, so it is high for exactly one clk_lf cycle, visible after the 2nd clk_lf rising edge that samples clk_game high.
REQ-017 FSM states SHALL be IDLE, PLAY and HOLD; encoding 11 is unreachable and SHALL recover to IDLE on the next edge.
REQ-018 In IDLE: level=0, hit_cnt=0, and hit and miss are ignored; start -> PLAY on the next edge.
REQ-019 In PLAY, a hit SHALL increment hit_cnt (4 bits).
REQ-020 In PLAY, a hit with hit_cnt==HITS_PER_LEVEL-1 SHALL set hit_cnt to 0 and set level to min(level+1, 3).
REQ-021 level_up SHALL pulse for 1 cycle, in the same cycle level changes, only if level was below 3 before the hit.
REQ-022 At level 3, hits SHALL keep cycling hit_cnt with no level change and no level_up.
REQ-023 In PLAY, a miss SHALL move the FSM to HOLD, clear hit_cnt, and load hold_cnt with HOLD_TICKS.
REQ-024 On the PLAY miss, if DROP_ON_MISS==1 and level>0, level SHALL decrement by 1; level SHALL never wrap below 0.
REQ-025 hit and miss in the same cycle SHALL be handled as a miss only; hit_cnt is not incremented.
REQ-026 In HOLD, hit, miss and start SHALL be ignored, and each game_tick SHALL decrement hold_cnt.
REQ-027 In HOLD, a game_tick with hold_cnt==1 SHALL return the FSM to PLAY on that edge.
REQ-028 freeze SHALL be a registered decode of state==HOLD and have no glitches.
REQ-029 start SHALL be ignored in PLAY and HOLD.
REQ-030 All outputs except game_tick SHALL be registered; level SHALL change only on a clk_lf rising edge.

Reset
REQ-031 btnC_n low SHALL immediately force: state=IDLE, level=0, level_up=0, freeze=0, game_tick=0, hit_cnt=0, hold_cnt=0, and all synchronizer flops=0.
REQ-032 Reset asserted mid-HOLD or mid-PLAY SHALL abandon the operation; after release the block waits in IDLE for start.
REQ-033 The first clk_lf edge after btnC_n rises SHALL evaluate normally; a start on that edge SHALL be accepted.

Verification
REQ-034 Default parameters: start, then 4 hit pulses -> level 0->1 on the 4th hit, level_up is one cycle wide, hit_cnt=0.
REQ-035 From level 3: 4 more hits -> level stays 3 and level_up never asserts.
REQ-036 At level 2: miss -> state=HOLD, freeze=1, level=1; hits during HOLD are ignored; after 3 clk_game rising edges -> state=PLAY, freeze=0.
REQ-037 Same-cycle hit and miss at hit_cnt=3 -> no level_up, level decrements, state=HOLD.
REQ-038 Square wave on clk_game with period 16 clk_lf cycles -> exactly one single-cycle game_tick per period, 2 cycles after each rise.
REQ-039 btnC_n pulsed low asynchronously mid-HOLD -> all outputs 0 at once, state=IDLE; a miss before start has no effect.
